// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_responder_pkg;

    localparam int WORD_BYTES    = 4;
    localparam int WORD_BITS     = WORD_BYTES * 8;
    localparam int BYTE_OFFSET_W = 2;

    // Wide enough to hold LOAD_LATENCY-1 for the largest latency of 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // True when every byte-address bit above the word index is zero.
    function automatic logic addr_in_range(input logic [31:0] byte_addr, input int addr_width);
        logic [31:0] upper;
        upper = byte_addr >> (addr_width + BYTE_OFFSET_W);
        return (upper == 32'd0);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core MEM-stage data port: load/store request side driven by the core (master),
// response side driven by the memory responder (slave).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic                  load_req;
    logic                  store_req;
    logic [31:0]           addr;
    logic [WORD_BITS-1:0]  data_in;
    logic [WORD_BYTES-1:0] be;
    logic                  mem_valid;
    logic [WORD_BITS-1:0]  data_out;
    logic                  err;

    modport master (
        output load_req, store_req, addr, data_in, be,
        input  mem_valid, data_out, err
    );

    modport slave (
        input  load_req, store_req, addr, data_in, be,
        output mem_valid, data_out, err
    );

endinterface

// File: rtl/dmem_responder_bytewise_ram.sv
// Word-wide RAM with per-byte-lane write enables and a registered read.
// One clock; the write address and read address are independent so a store
// arriving on the same edge as a pending load's read never stalls either one.
// A read and a write to the same word on the same edge return the old word.
module bytewise_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter     INIT_FILE  = ""
) (
    input  logic                    i_clk,
    input  logic [DATA_WIDTH/8-1:0] wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_data_p1;

    // Read-first port: the read register samples the word before this edge's lane writes land.
    always_ff @(posedge i_clk) begin
        if (rd_en) begin
            rd_data_p1 <= mem[rd_addr];
        end
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    assign rd_data = rd_data_p1;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the core's MEM-stage port. Stores complete on the edge
// they are presented; loads are answered with a one-cycle valid pulse after a
// configurable number of wait cycles so the core's load stall path can be exercised.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int LOAD_LATENCY = 2,
    parameter     INIT_FILE    = ""
) (
    input  logic            i_clk,
    input  logic            i_rst,
    dmem_responder_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LOAD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    dmem_state_e           state_q;
    dmem_state_e           state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [ADDR_WIDTH-1:0] ld_addr_p0;
    logic                  ld_oor_p0;
    logic                  err_p1;
    logic [WORD_BITS-1:0]  hold_p1;
    logic                  run_q;

    logic                  store_act;
    logic                  in_range;
    logic                  in_idle;
    logic                  load_take;
    logic                  collide;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [WORD_BYTES-1:0] ram_wr_en;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [WORD_BITS-1:0]  ram_rd_data;
    logic [WORD_BITS-1:0]  resp_word;

    // Request decode. run_q is low only until the first edge after reset
    // release, which suppresses a store presented on that edge.
    assign store_act = bus.store_req & run_q;
    assign in_range  = addr_in_range(bus.addr, ADDR_WIDTH);
    assign word_idx  = bus.addr[ADDR_WIDTH+1:2];
    assign in_idle   = (state_q == DMEM_IDLE);
    assign collide   = in_idle & bus.load_req & store_act;
    assign load_take = in_idle & bus.load_req & ~store_act;
    assign ram_wr_en = (store_act & in_range) ? bus.be : '0;

    // Next-state, latency countdown and RAM read issue.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = ld_addr_p0;
        case (state_q)
            DMEM_IDLE: begin
                if (load_take) begin
                    capture = 1'b1;
                    cnt_d   = CNT_START;
                    if (LOAD_LATENCY == 1) begin
                        ram_rd_en   = 1'b1;
                        ram_rd_addr = word_idx;
                        state_d     = DMEM_RESP;
                    end else begin
                        state_d = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                // Reading on the last wait edge lets stores made during the wait reach the load.
                if (cnt_q == CNT_ONE) begin
                    ram_rd_en = 1'b1;
                    state_d   = DMEM_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DMEM_RESP: begin
                state_d = DMEM_IDLE;
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase
    end

    // FSM state, countdown, load range flag, error pulse and post-reset store guard.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= DMEM_IDLE;
            cnt_q     <= '0;
            ld_oor_p0 <= 1'b0;
            err_p1    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            if (capture) begin
                ld_oor_p0 <= ~in_range;
            end
            err_p1 <= collide | (store_act & ~in_range) | (load_take & ~in_range);
        end
    end

    // Captured word index of the load in flight.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            ld_addr_p0 <= word_idx;
        end
    end

    // Keeps the last response word on the output between responses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_p1 <= '0;
        end else if (state_q == DMEM_RESP) begin
            hold_p1 <= resp_word;
        end
    end

    bytewise_ram #(
        .DATA_WIDTH (WORD_BITS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .i_clk   (i_clk),
        .wr_en   (ram_wr_en),
        .wr_addr (word_idx),
        .wr_data (bus.data_in),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // Out-of-range loads still take the normal path but answer with zero.
    assign resp_word     = ld_oor_p0 ? '0 : ram_rd_data;
    assign bus.mem_valid = (state_q == DMEM_RESP);
    assign bus.data_out  = (state_q == DMEM_RESP) ? resp_word : hold_p1;
    assign bus.err       = err_p1;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (load latency 1, 3 and 4) share a
// clock and reset; directed scenarios followed by random traffic checked
// against a word-array memory model.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;

    logic [2:0]        load_req;
    logic [2:0]        store_req;
    logic [2:0][31:0]  addr;
    logic [2:0][31:0]  data_in;
    logic [2:0][3:0]   be;
    logic [2:0]        mem_valid;
    logic [2:0][31:0]  data_out;
    logic [2:0]        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [3][1024];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        dmem_responder_if bus ();
        assign bus.load_req  = load_req[g];
        assign bus.store_req = store_req[g];
        assign bus.addr      = addr[g];
        assign bus.data_in   = data_in[g];
        assign bus.be        = be[g];
        assign mem_valid[g]  = bus.mem_valid;
        assign data_out[g]   = bus.data_out;
        assign err[g]        = bus.err;
        dmem_responder #(
            .ADDR_WIDTH   (10),
            .LOAD_LATENCY (LAT),
            .INIT_FILE    ("")
        ) u_dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (bus)
        );
    end

    function automatic int lat(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory model: in-range stores update enabled lanes; others are dropped.
    task automatic model_store(input int k, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] b);
        if (a[31:12] == 20'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) ref_mem[k][a[11:2]][i*8 +: 8] = d[i*8 +: 8];
            end
        end
    endtask

    task automatic do_store(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
        store_req[k] = 1'b1;
        addr[k]      = a;
        data_in[k]   = d;
        be[k]        = b;
        @(posedge clk); #1;
        store_req[k] = 1'b0;
        model_store(k, a, d, b);
        check($sformatf("st%0d_err", k), 32'(err[k]), 32'(a[31:12] != 20'd0));
        check($sformatf("st%0d_novalid", k), 32'(mem_valid[k]), 32'd0);
    endtask

    // Holds a load on instance k from the current cycle; optionally presents a
    // store on wait cycle st_cyc. The response must appear exactly LAT cycles
    // after the request is first sampled and carry the word as it stood before
    // the final wait edge's store.
    task automatic do_load(input int k, input logic [31:0] a, input int st_cyc,
                           input logic [31:0] st_a, input logic [31:0] st_d,
                           input logic [3:0] st_b, input bit keep,
                           output logic [31:0] got);
        int          L;
        bit          oor;
        logic [31:0] exp_d;
        L           = lat(k);
        oor         = (a[31:12] != 20'd0);
        exp_d       = 32'd0;
        load_req[k] = 1'b1;
        addr[k]     = a;
        for (int c = 0; c < L; c++) begin
            if (c == st_cyc && c > 0) begin
                store_req[k] = 1'b1;
                addr[k]      = st_a;
                data_in[k]   = st_d;
                be[k]        = st_b;
            end
            if (c == L - 1) exp_d = oor ? 32'd0 : ref_mem[k][a[11:2]];
            @(posedge clk); #1;
            if (store_req[k]) begin
                model_store(k, st_a, st_d, st_b);
                store_req[k] = 1'b0;
                addr[k]      = a;
            end
            if (c == 0) check($sformatf("ld%0d_err", k), 32'(err[k]), 32'(oor));
            if (c < L - 1) check($sformatf("ld%0d_early_valid", k), 32'(mem_valid[k]), 32'd0);
        end
        check($sformatf("ld%0d_valid", k), 32'(mem_valid[k]), 32'd1);
        check($sformatf("ld%0d_data", k), data_out[k], exp_d);
        got = data_out[k];
        if (!keep) begin
            load_req[k] = 1'b0;
            @(posedge clk); #1;
            check($sformatf("ld%0d_single_pulse", k), 32'(mem_valid[k]), 32'd0);
            check($sformatf("ld%0d_hold", k), data_out[k], exp_d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          sel;
        int          sc;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] got;
        logic [31:0] sa;
        logic [3:0]  b;
        bit          any_v;

        rst       = 1'b1;
        load_req  = '0;
        store_req = '0;
        addr      = '0;
        data_in   = '0;
        be        = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d_valid", i), 32'(mem_valid[i]), 32'd0);
            check($sformatf("rst%0d_data", i), data_out[i], 32'd0);
            check($sformatf("rst%0d_err", i), 32'(err[i]), 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Latency 1: response the cycle after the request
        do_store(0, 32'h10, 32'hDEADBEEF, 4'b1111);
        do_load(0, 32'h10, -1, 0, 0, 0, 1'b0, got);
        check("t1_const", got, 32'hDEADBEEF);

        // Latency 3: partial-lane merge
        do_store(1, 32'h20, 32'h11223344, 4'b1111);
        do_store(1, 32'h20, 32'h0000AA00, 4'b0010);
        do_load(1, 32'h20, -1, 0, 0, 0, 1'b0, got);
        check("t2_const", got, 32'h1122AA44);

        // Latency 4: store to the same word during the wait is seen by the load
        do_store(2, 32'h30, 32'h12345678, 4'b1111);
        do_load(2, 32'h30, 1, 32'h30, 32'hCAFEF00D, 4'b1111, 1'b0, got);
        check("t3_const", got, 32'hCAFEF00D);

        // Back-to-back loads with the request held across both
        do_store(1, 32'h0, 32'hA5A50001, 4'b1111);
        do_store(1, 32'h4, 32'h5A5A0002, 4'b1111);
        do_load(1, 32'h0, -1, 0, 0, 0, 1'b1, got);
        check("t6_first", got, 32'hA5A50001);
        addr[1] = 32'h4;
        @(posedge clk); #1;
        check("t6_gap_valid", 32'(mem_valid[1]), 32'd0);
        do_load(1, 32'h4, -1, 0, 0, 0, 1'b0, got);
        check("t6_second", got, 32'h5A5A0002);

        // Out-of-range load and store
        do_load(1, 32'h00001000, -1, 0, 0, 0, 1'b0, got);
        check("t4_oor_load", got, 32'd0);
        do_store(1, 32'h00001004, 32'hFFFFFFFF, 4'b1111);
        do_load(1, 32'h0, -1, 0, 0, 0, 1'b0, got);
        check("t4_word0", got, 32'hA5A50001);
        do_load(1, 32'h4, -1, 0, 0, 0, 1'b0, got);
        check("t4_word1", got, 32'h5A5A0002);

        // Load and store together in idle: store lands, load deferred, error pulse
        load_req[1]  = 1'b1;
        store_req[1] = 1'b1;
        addr[1]      = 32'h50;
        data_in[1]   = 32'h0BADF00D;
        be[1]        = 4'b1111;
        @(posedge clk); #1;
        store_req[1] = 1'b0;
        model_store(1, 32'h50, 32'h0BADF00D, 4'b1111);
        check("coll_err", 32'(err[1]), 32'd1);
        check("coll_novalid", 32'(mem_valid[1]), 32'd0);
        do_load(1, 32'h50, -1, 0, 0, 0, 1'b0, got);
        check("coll_data", got, 32'h0BADF00D);

        // Zero byte enables are a no-op
        do_store(0, 32'h40, 32'h01020304, 4'b1111);
        do_store(0, 32'h40, 32'hFFFFFFFF, 4'b0000);
        do_load(0, 32'h42, -1, 0, 0, 0, 1'b0, got);
        check("be0_const", got, 32'h01020304);

        // Asynchronous reset while a load is waiting
        do_load(2, 32'h30, -1, 0, 0, 0, 1'b0, got);
        load_req[2] = 1'b1;
        addr[2]     = 32'h00002000;
        @(posedge clk); #1;
        check("t5_err_before", 32'(err[2]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_valid_cleared", 32'(mem_valid[2]), 32'd0);
        check("t5_data_cleared", data_out[2], 32'd0);
        check("t5_err_cleared", 32'(err[2]), 32'd0);
        load_req[2] = 1'b0;
        @(posedge clk); #1;
        rst   = 1'b0;
        any_v = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            any_v = any_v | (|mem_valid);
        end
        check("t5_no_late_valid", 32'(any_v), 32'd0);
        do_load(2, 32'h30, -1, 0, 0, 0, 1'b0, got);
        check("t5_ram_intact", got, 32'hCAFEF00D);

        // Random traffic over a 16-word pool, after giving every pool word a value
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 16; w++) begin
                do_store(i, 32'h100 + 32'(w * 4), $urandom, 4'b1111);
            end
        end
        for (int it = 0; it < 150; it++) begin
            k   = $urandom_range(0, 2);
            sel = $urandom_range(0, 9);
            a   = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            d   = $urandom;
            b   = 4'($urandom);
            if (sel < 4) begin
                do_store(k, a, d, b);
            end else if (sel == 4) begin
                do_store(k, a | 32'h00001000, d, b);
            end else if (sel == 5) begin
                do_load(k, a | 32'h00004000, -1, 0, 0, 0, 1'b0, got);
            end else begin
                sc = (lat(k) > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, lat(k) - 1) : -1;
                sa = 32'h100 + 32'($urandom_range(0, 15) * 4);
                do_load(k, a, sc, sa, d, b, 1'b0, got);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
